// File: rtl/nibbler_mem_pkg.sv
// Shared types and constants for the NibblER data-memory initiator.
// Provides the FSM state encoding, the captured-request record and a nibble extractor.
package nibbler_mem_pkg;

   localparam int ADDR_W       = 12;
   localparam int DATA_W       = 4;
   localparam int WORD_NIBBLES = 4;
   localparam int WORD_W       = DATA_W * WORD_NIBBLES;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_SAMPLE,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD,
      DONE
   } mem_state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        len;
      logic [WORD_W-1:0] wdata;
   } mem_req_t;

   function automatic logic [DATA_W-1:0] nibble_of(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        i);
      return w[i*DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/ram_bus_master.sv
// Initiator for the NibblER nibble RAM: splits a 16-bit word request into 1-4
// single-nibble accesses at consecutive addresses and owns the shared data bus enable.
module ram_bus_master
   import nibbler_mem_pkg::*;
#(
   parameter int ADDR_W  = nibbler_mem_pkg::ADDR_W,
   parameter int DATA_W  = nibbler_mem_pkg::DATA_W,
   parameter int RD_WAIT = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_we,
   input  logic [ADDR_W-1:0]              req_addr,
   input  logic [1:0]                     req_len,
   input  logic [WORD_NIBBLES*DATA_W-1:0] req_wdata,
   output logic                           rsp_valid,
   output logic [WORD_NIBBLES*DATA_W-1:0] rsp_rdata,
   output logic                           ram_cs,
   output logic                           ram_we,
   output logic [ADDR_W-1:0]              ram_addr,
   inout  wire  [DATA_W-1:0]              ram_data
);

   localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT);

   mem_state_t                     state_q;
   mem_req_t                       req_q;
   logic [1:0]                     idx_q;
   logic [1:0]                     wait_q;
   logic [WORD_NIBBLES*DATA_W-1:0] acc_q;
   logic [WORD_NIBBLES*DATA_W-1:0] rdata_q;
   logic                           rsp_valid_q;
   logic                           ready_q;
   logic                           cs_q;
   logic                           we_q;
   logic [ADDR_W-1:0]              addr_q;
   logic                           oe_q;
   logic [DATA_W-1:0]              dout_q;
   logic [WORD_NIBBLES*DATA_W-1:0] rd_word_d;

   // Accumulated word with the nibble currently on the bus merged in.
   always_comb begin
      rd_word_d = acc_q;
      rd_word_d[idx_q*DATA_W +: DATA_W] = ram_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= '0;
         idx_q       <= '0;
         wait_q      <= '0;
         acc_q       <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b1;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         oe_q        <= 1'b0;
         dout_q      <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid && ready_q) begin
                  req_q   <= '{we: req_we, addr: req_addr, len: req_len, wdata: req_wdata};
                  idx_q   <= '0;
                  wait_q  <= '0;
                  acc_q   <= '0;
                  ready_q <= 1'b0;
                  cs_q    <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= req_addr;
                  dout_q  <= req_wdata[DATA_W-1:0];
                  oe_q    <= req_we;
                  state_q <= req_we ? WR_SETUP : RD_ADDR;
               end
            end
            RD_ADDR: begin
               if (wait_q == WAIT_LAST) begin
                  state_q <= RD_SAMPLE;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end
            WR_SETUP: begin
               we_q    <= 1'b1;
               state_q <= WR_STROBE;
            end
            WR_STROBE: begin
               we_q    <= 1'b0;
               state_q <= WR_HOLD;
            end
            RD_SAMPLE, WR_HOLD: begin
               if (state_q == RD_SAMPLE) begin
                  acc_q <= rd_word_d;
               end
               if (idx_q == req_q.len) begin
                  // Bus enable drops on the same edge as chip select.
                  state_q     <= DONE;
                  cs_q        <= 1'b0;
                  oe_q        <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  if (!req_q.we) begin
                     rdata_q <= rd_word_d;
                  end
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  wait_q  <= '0;
                  addr_q  <= req_q.addr + ADDR_W'(idx_q + 2'd1);
                  dout_q  <= nibble_of(req_q.wdata, idx_q + 2'd1);
                  state_q <= req_q.we ? WR_SETUP : RD_ADDR;
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               cs_q    <= 1'b0;
               we_q    <= 1'b0;
               oe_q    <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign ram_cs    = cs_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_data  = oe_q ? dout_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: nibble RAM model on the bus, a queue-based cycle model
// built from request-level rules, and directed plus random request streams.
module tb_ram_bus_master;

   localparam int RD_WAIT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [11:0] req_addr;
   logic [1:0]  req_len;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        ram_cs;
   logic        ram_we;
   logic [11:0] ram_addr;
   wire  [3:0]  ram_data;

   ram_bus_master #(.ADDR_W(12), .DATA_W(4), .RD_WAIT(RD_WAIT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data)
   );

   always #5 clk = ~clk;

   // RAM on the bus: writes on a clock edge with cs&we, drives read data only for read transfers.
   logic [3:0] mem     [0:4095] = '{default: 4'h0};
   logic [3:0] ref_mem [0:4095] = '{default: 4'h0};
   logic       rd_busy = 1'b0;

   assign ram_data = (ram_cs && !ram_we && rd_busy) ? mem[ram_addr] : 4'bz;

   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        cs;
      logic        we;
      logic        rdy;
      logic        rsp;
      logic        chk_wd;
      logic [11:0] addr;
      logic [3:0]  wd;
      logic [15:0] rdata;
   } exp_t;

   exp_t        q[$];
   logic [15:0] exp_rdata = 16'h0;
   logic        chk_en = 1'b0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          last_lat = -1;
   int          n_acc = 0;
   int          n_rsp = 0;
   int          we_cnt = 0;
   logic [3:0]  we_data = 4'h0;

   function automatic exp_t mk(input logic cs, input logic we, input logic rsp, input logic chk_wd,
                               input logic [11:0] a, input logic [3:0] d, input logic [15:0] rd);
      exp_t e;
      e.cs = cs; e.we = we; e.rdy = 1'b0; e.rsp = rsp; e.chk_wd = chk_wd;
      e.addr = a; e.wd = d; e.rdata = rd;
      return e;
   endfunction

   // Request-level model: expands one accepted request into its expected bus cycles.
   function automatic void model_accept(input logic we, input logic [11:0] base,
                                        input logic [1:0] len, input logic [15:0] wdata);
      logic [15:0] w;
      logic [11:0] a;
      logic [3:0]  d;
      w = 16'h0;
      for (int n = 0; n <= int'(len); n++) begin
         a = base + 12'(n);
         if (we) begin
            d = wdata[4*n +: 4];
            ref_mem[a] = d;
            for (int s = 0; s < 3; s++) q.push_back(mk(1'b1, s == 1, 1'b0, 1'b1, a, d, exp_rdata));
         end else begin
            w[4*n +: 4] = ref_mem[a];
            for (int s = 0; s < RD_WAIT + 2; s++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, a, 4'h0, exp_rdata));
         end
      end
      if (!we) exp_rdata = w;
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, exp_rdata));
      rd_busy = !we;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         q.delete();
         exp_rdata = 16'h0;
         rd_busy = 1'b0;
      end else if (chk_en) begin
         if (q.size() > 0) e = q.pop_front();
         else begin
            e = mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, exp_rdata);
            e.rdy = 1'b1;
         end
         chk("ram_cs", 32'(ram_cs), 32'(e.cs));
         chk("ram_we", 32'(ram_we), 32'(e.we));
         chk("req_ready", 32'(req_ready), 32'(e.rdy));
         chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
         chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
         if (e.cs) chk("ram_addr", 32'(ram_addr), 32'(e.addr));
         if (e.chk_wd) chk("ram_data", 32'(ram_data), 32'(e.wd));
         if (ram_we) begin
            we_cnt++;
            we_data = ram_data;
         end
         if (rsp_valid) begin
            n_rsp++;
            last_lat = cyc - acc_cyc;
            rd_busy = 1'b0;
         end
         if (req_valid && req_ready) begin
            n_acc++;
            acc_cyc = cyc;
            model_accept(req_we, req_addr, req_len, req_wdata);
         end
      end
   end

   task automatic issue(input logic we, input logic [11:0] a, input logic [1:0] l, input logic [15:0] d);
      req_we = we; req_addr = a; req_len = l; req_wdata = d; req_valid = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (req_ready) break;
         if (t > 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (q.size() == 0) break;
         if (t > 100) begin
            chk("done_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   int          w0, a0, r0, a_cyc;
   logic [11:0] rb;

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_cs", 32'(ram_cs), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // single write then read
      w0 = we_cnt;
      issue(1'b1, 12'h000, 2'd0, 16'h0003);
      wait_done();
      chk("wr1_we_cycles", 32'(we_cnt - w0), 32'd1);
      chk("wr1_we_data", 32'(we_data), 32'h3);
      chk("wr1_mem0", 32'(mem[0]), 32'h3);
      chk("wr1_latency", 32'(last_lat), 32'd4);
      issue(1'b0, 12'h000, 2'd0, 16'h0);
      wait_done();
      chk("rd1_rdata", 32'(rsp_rdata), 32'h0003);
      chk("rd1_latency", 32'(last_lat), 32'd4);

      // burst, with a nonzero nibble just past the read window
      issue(1'b1, 12'h004, 2'd0, 16'h000F);
      issue(1'b1, 12'h001, 2'd2, 16'h06C3);
      wait_done();
      chk("burst_mem1", 32'(mem[1]), 32'h3);
      chk("burst_mem2", 32'(mem[2]), 32'hC);
      chk("burst_mem3", 32'(mem[3]), 32'h6);
      issue(1'b0, 12'h001, 2'd2, 16'h0);
      wait_done();
      chk("burst_rdata", 32'(rsp_rdata), 32'h06C3);
      chk("burst_latency", 32'(last_lat), 32'd10);

      // address wrap
      issue(1'b1, 12'hFFE, 2'd3, 16'hDCBA);
      wait_done();
      chk("wrap_memFFE", 32'(mem[12'hFFE]), 32'hA);
      chk("wrap_memFFF", 32'(mem[12'hFFF]), 32'hB);
      chk("wrap_mem000", 32'(mem[12'h000]), 32'hC);
      chk("wrap_mem001", 32'(mem[12'h001]), 32'hD);
      issue(1'b0, 12'hFFE, 2'd3, 16'h0);
      wait_done();
      chk("wrap_rdata", 32'(rsp_rdata), 32'hDCBA);

      // second request held while the first is busy
      a0 = n_acc; r0 = n_rsp;
      issue(1'b0, 12'h001, 2'd2, 16'h0);
      a_cyc = acc_cyc;
      issue(1'b1, 12'h100, 2'd1, 16'h0075);
      chk("hs_accept_gap", 32'(acc_cyc - a_cyc), 32'd11);
      wait_done();
      chk("hs_accepts", 32'(n_acc - a0), 32'd2);
      chk("hs_responses", 32'(n_rsp - r0), 32'd2);

      // reset during the strobe of the second nibble of a write
      chk_en = 1'b0;
      issue(1'b1, 12'h800, 2'd1, 16'h0021);
      repeat (4) @(posedge clk);
      #2;
      chk("mid_we_before", 32'(ram_we), 32'd1);
      chk("mid_addr_before", 32'(ram_addr), 32'h801);
      rst_n = 1'b0;
      #1;
      chk("mid_cs", 32'(ram_cs), 32'd0);
      chk("mid_we", 32'(ram_we), 32'd0);
      chk("mid_ready", 32'(req_ready), 32'd1);
      chk("mid_rsp", 32'(rsp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_mem800", 32'(mem[12'h800]), 32'h1);
      chk("mid_mem801", 32'(mem[12'h801]), 32'h0);
      chk("mid_rdata_cleared", 32'(rsp_rdata), 32'h0);
      chk_en = 1'b1;

      // mixed random traffic, keeping clear of the aborted-write region
      a0 = n_acc; r0 = n_rsp;
      for (int i = 0; i < 1000; i++) begin
         rb = 12'($urandom_range(0, 4095));
         if (rb >= 12'h7F8 && rb <= 12'h80F) rb = rb + 12'h20;
         issue(1'($urandom_range(0, 1)), rb, 2'($urandom_range(0, 3)), 16'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      wait_done();
      chk("rand_accepts", 32'(n_acc - a0), 32'd1000);
      chk("rand_responses", 32'(n_rsp - r0), 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
